// File: rtl/ram_io_responder_if.sv
// ram_io_responder_if: byte-serial memory bus between the controller (master) and the RAM/IO responder (slave)
interface ram_io_responder_if;
    logic        rdy_in;
    logic [31:0] addr_in;
    logic        rw_flag_in;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        uart_full_out;
    modport master (output rdy_in, addr_in, rw_flag_in, data_in, input data_out, uart_full_out);
    modport slave (input rdy_in, addr_in, rw_flag_in, data_in, output data_out, uart_full_out);
endinterface

// File: rtl/ram_io_responder.sv
// ram_io_responder: byte RAM with one-cycle read latency plus UART TX/RX FIFOs, status and sim-end strobe at 0x30000
module ram_io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    ram_io_responder_if.slave   bus,
    output logic                tx_valid_out,
    output logic [7:0]          tx_data_out,
    input  logic                tx_ready_in,
    input  logic                rx_valid_in,
    input  logic [7:0]          rx_data_in,
    output logic                sim_end_out,
    output logic                tx_overflow_out
);
    localparam int TPW = $clog2(TX_DEPTH);
    localparam int RPW = $clog2(RX_DEPTH);
    localparam logic [TPW:0] TX_N = (TPW+1)'(TX_DEPTH);
    localparam logic [TPW:0] TX_HI = (TPW+1)'(TX_DEPTH - 2);
    localparam logic [RPW:0] RX_N = (RPW+1)'(RX_DEPTH);
    logic [7:0] mem [2**RAM_ADDR_WIDTH];
    logic [7:0] tx_mem [TX_DEPTH];
    logic [7:0] rx_mem [RX_DEPTH];
    logic [TPW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [TPW:0] tx_cnt_q, tx_cnt_d;
    logic [RPW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [RPW:0] rx_cnt_q, rx_cnt_d;
    logic [7:0] data_out_q, data_out_d;
    logic uart_full_q, uart_full_d, sim_end_q, sim_end_d, tx_ovf_q, tx_ovf_d;
    logic io, off0, off4, wr, rd, tx_full, tx_push, tx_pop, tx_acc, rx_ne, rx_pop, rx_acc;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic unused_addr;
    assign unused_addr = ^bus.addr_in[31:18];
    assign tx_valid_out = tx_cnt_q != '0;
    assign tx_data_out = tx_valid_out ? tx_mem[tx_rp_q] : 8'h00;
    assign bus.data_out = data_out_q;
    assign bus.uart_full_out = uart_full_q;
    assign sim_end_out = sim_end_q;
    assign tx_overflow_out = tx_ovf_q;
    always_comb begin
        io = bus.addr_in[17:16] == 2'b11;
        off0 = io && bus.addr_in[15:0] == 16'h0000;
        off4 = io && bus.addr_in[15:0] == 16'h0004;
        wr = bus.rdy_in && bus.rw_flag_in;
        rd = bus.rdy_in && !bus.rw_flag_in;
        ram_idx = bus.addr_in[RAM_ADDR_WIDTH-1:0];
        tx_full = tx_cnt_q == TX_N;
        tx_push = wr && off0;
        tx_pop = bus.rdy_in && tx_valid_out && tx_ready_in;
        // a push into a full FIFO still fits when the head leaves in the same cycle
        tx_acc = tx_push && (!tx_full || tx_pop);
        tx_wp_d = tx_wp_q + TPW'(tx_acc);
        tx_rp_d = tx_rp_q + TPW'(tx_pop);
        tx_cnt_d = tx_cnt_q + (TPW+1)'(tx_acc) - (TPW+1)'(tx_pop);
        uart_full_d = tx_cnt_d >= TX_HI;
        tx_ovf_d = tx_ovf_q || (tx_push && !tx_acc);
        rx_ne = rx_cnt_q != '0;
        rx_pop = rd && off0 && rx_ne;
        rx_acc = bus.rdy_in && rx_valid_in && (rx_cnt_q != RX_N || rx_pop);
        rx_wp_d = rx_wp_q + RPW'(rx_acc);
        rx_rp_d = rx_rp_q + RPW'(rx_pop);
        rx_cnt_d = rx_cnt_q + (RPW+1)'(rx_acc) - (RPW+1)'(rx_pop);
        sim_end_d = wr && off4;
        data_out_d = wr ? 8'h00 : !io ? mem[ram_idx] : off0 ? (rx_ne ? rx_mem[rx_rp_q] : 8'h00) :
                     off4 ? {6'b0, tx_full, rx_ne} : 8'h00;
    end
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            tx_wp_q <= '0;
            tx_rp_q <= '0;
            tx_cnt_q <= '0;
            rx_wp_q <= '0;
            rx_rp_q <= '0;
            rx_cnt_q <= '0;
            data_out_q <= 8'h00;
            uart_full_q <= 1'b0;
            sim_end_q <= 1'b0;
            tx_ovf_q <= 1'b0;
        end else if (bus.rdy_in) begin
            tx_wp_q <= tx_wp_d;
            tx_rp_q <= tx_rp_d;
            tx_cnt_q <= tx_cnt_d;
            rx_wp_q <= rx_wp_d;
            rx_rp_q <= rx_rp_d;
            rx_cnt_q <= rx_cnt_d;
            data_out_q <= data_out_d;
            uart_full_q <= uart_full_d;
            sim_end_q <= sim_end_d;
            tx_ovf_q <= tx_ovf_d;
        end
    end
    // storage arrays carry no reset; only the pointers define FIFO contents
    always_ff @(posedge clk_in) begin
        if (rst_n_in && wr && !io) mem[ram_idx] <= bus.data_in;
        if (rst_n_in && tx_acc) tx_mem[tx_wp_q] <= bus.data_in;
        if (rst_n_in && rx_acc) rx_mem[rx_wp_q] <= rx_data_in;
    end
endmodule

// File: tb/tb_ram_io_responder.sv
// tb_ram_io_responder: directed checks of RAM, aliasing, TX/RX FIFOs, sim-end, rdy_in and reset behaviour
module tb_ram_io_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx_valid, sim_end, tx_ovf;
    logic [7:0] tx_data;
    logic tx_ready = 1'b0;
    logic rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    int compared = 0;
    int mismatched = 0;
    ram_io_responder_if bus();
    ram_io_responder dut (
        .clk_in(clk), .rst_n_in(rst_n), .bus(bus),
        .tx_valid_out(tx_valid), .tx_data_out(tx_data), .tx_ready_in(tx_ready),
        .rx_valid_in(rx_valid), .rx_data_in(rx_data),
        .sim_end_out(sim_end), .tx_overflow_out(tx_ovf)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step(input logic [31:0] a, input logic w, input logic [7:0] d);
        bus.addr_in = a;
        bus.rw_flag_in = w;
        bus.data_in = d;
        @(posedge clk);
        #1;
    endtask
    initial begin
        bus.rdy_in = 1'b1;
        bus.addr_in = 32'h0;
        bus.rw_flag_in = 1'b0;
        bus.data_in = 8'h00;
        step(32'h0, 1'b0, 8'h00);
        step(32'h0, 1'b0, 8'h00);
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_uart_full", bus.uart_full_out, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_sim_end", sim_end, 0);
        chk("rst_tx_ovf", tx_ovf, 0);
        rst_n = 1'b1;
        step(32'h00010, 1'b1, 8'hA5);
        chk("wr_data_out_zero", bus.data_out, 0);
        step(32'h00011, 1'b1, 8'h5A);
        step(32'h00010, 1'b0, 8'h00);
        chk("ram_rd_10", bus.data_out, 8'hA5);
        step(32'h00011, 1'b0, 8'h00);
        chk("ram_rd_11", bus.data_out, 8'h5A);
        step(32'h20010, 1'b1, 8'h3C);
        step(32'h00010, 1'b0, 8'h00);
        chk("alias_rd_10", bus.data_out, 8'h3C);
        step(32'h00010, 1'b1, 8'hA5);
        for (int i = 0; i < 6; i++) begin
            step(32'h30000, 1'b1, 8'(8'h10 + i));
            if (i == 4) chk("uart_full_after5", bus.uart_full_out, 0);
        end
        chk("uart_full_after6", bus.uart_full_out, 1);
        step(32'h30000, 1'b1, 8'h16);
        step(32'h30000, 1'b1, 8'h17);
        chk("tx_valid_8", tx_valid, 1);
        chk("tx_head_8", tx_data, 8'h10);
        chk("tx_ovf_8", tx_ovf, 0);
        step(32'h30004, 1'b0, 8'h00);
        chk("status_tx_full", bus.data_out, 8'h02);
        step(32'h30000, 1'b1, 8'hEE);
        chk("tx_ovf_9", tx_ovf, 1);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("tx_order", tx_data, 32'(8'h10 + i));
            step(32'h0, 1'b0, 8'h00);
            chk("uart_full_drain", bus.uart_full_out, (7 - i) >= 6);
        end
        chk("tx_empty", tx_valid, 0);
        chk("tx_ovf_sticky", tx_ovf, 1);
        tx_ready = 1'b0;
        rx_valid = 1'b1;
        rx_data = 8'h41;
        step(32'h0, 1'b0, 8'h00);
        rx_data = 8'h42;
        step(32'h0, 1'b0, 8'h00);
        rx_valid = 1'b0;
        step(32'h30004, 1'b0, 8'h00);
        chk("status_rx_ne", bus.data_out, 8'h01);
        step(32'h30000, 1'b0, 8'h00);
        chk("rx_pop_41", bus.data_out, 8'h41);
        step(32'h30000, 1'b0, 8'h00);
        chk("rx_pop_42", bus.data_out, 8'h42);
        step(32'h30000, 1'b0, 8'h00);
        chk("rx_pop_empty", bus.data_out, 8'h00);
        step(32'h30004, 1'b0, 8'h00);
        chk("status_rx_empty", bus.data_out, 8'h00);
        step(32'h30004, 1'b1, 8'h00);
        chk("sim_end_pulse", sim_end, 1);
        step(32'h0, 1'b0, 8'h00);
        chk("sim_end_one_cycle", sim_end, 0);
        step(32'h00020, 1'b1, 8'h77);
        step(32'h00020, 1'b0, 8'h00);
        chk("ram_rd_20", bus.data_out, 8'h77);
        bus.rdy_in = 1'b0;
        rx_valid = 1'b1;
        rx_data = 8'h55;
        step(32'h00020, 1'b1, 8'h99);
        chk("rdy_low_hold", bus.data_out, 8'h77);
        bus.rdy_in = 1'b1;
        rx_valid = 1'b0;
        step(32'h00020, 1'b0, 8'h00);
        chk("rdy_low_no_write", bus.data_out, 8'h77);
        step(32'h30004, 1'b0, 8'h00);
        chk("rdy_low_rx_lost", bus.data_out, 8'h00);
        for (int i = 0; i < 3; i++) step(32'h30000, 1'b1, 8'(8'h80 + i));
        rx_valid = 1'b1;
        rx_data = 8'h66;
        step(32'h0, 1'b0, 8'h00);
        rx_valid = 1'b0;
        chk("pre_rst_tx_valid", tx_valid, 1);
        chk("pre_rst_uart_full", bus.uart_full_out, 0);
        rst_n = 1'b0;
        step(32'h0, 1'b0, 8'h00);
        rst_n = 1'b1;
        chk("mid_rst_tx_valid", tx_valid, 0);
        chk("mid_rst_uart_full", bus.uart_full_out, 0);
        chk("mid_rst_tx_ovf", tx_ovf, 0);
        step(32'h00010, 1'b0, 8'h00);
        chk("ram_survives_rst", bus.data_out, 8'hA5);
        step(32'h30004, 1'b0, 8'h00);
        chk("rx_cleared_by_rst", bus.data_out, 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
